// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-read-port register bank with byte-lane write
// strobes, write-to-read forwarding and a command-driven bulk-clear sequencer.
// Optional parity storage/checking is enabled by `define REGISTER_BANK_PARITY_EN.
module register_bank_mp #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 32,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int NB     = WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_w_en,
  input  logic [AW-1:0]           i_w_addr,
  input  logic [WIDTH-1:0]        i_w_value,
  input  logic [NB-1:0]           i_w_strb,
  output logic                    o_w_drop,
  input  logic [NUM_RD-1:0]       i_r_en,
  input  logic [NUM_RD*AW-1:0]    i_r_addr,
  output logic [NUM_RD*WIDTH-1:0] o_r_value,
  output logic [NUM_RD-1:0]       o_r_valid,
  input  logic                    i_clr,
  output logic                    o_busy
`ifdef REGISTER_BANK_PARITY_EN
  ,
  input  logic                    i_perr_inj,
  output logic [NUM_RD-1:0]       o_r_perr
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_ptr;
  logic [AW-1:0]     w_ptr_nxt;
  logic              r_busy;
  logic              r_drop;

  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_idle;
  logic              w_access_ok;
  logic              w_w_in_range;
  logic [AW-1:0]     w_w_idx;
  logic              w_wr_ok;
  logic              w_wr_drop;
  logic [WIDTH-1:0]  w_old;
  logic [WIDTH-1:0]  w_merged;

  // Accesses are only honoured in IDLE and not in the cycle a clear is taken.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_access_ok  = w_idle && !i_clr;
  assign w_w_in_range = ({1'b0, i_w_addr} < DEPTH_W);
  assign w_w_idx      = w_w_in_range ? i_w_addr : '0;
  assign w_wr_ok      = i_w_en && w_access_ok && w_w_in_range;
  assign w_wr_drop    = i_w_en && !w_wr_ok;
  assign w_old        = r_mem[w_w_idx];

  // Byte-lane merge of new write data over the currently stored word.
  always_comb begin
    w_merged = w_old;
    for (int unsigned b = 0; b < NB; b++) begin
      if (i_w_strb[b]) begin
        w_merged[b*8 +: 8] = i_w_value[b*8 +: 8];
      end
    end
  end

  // Clear sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt == ST_CLEARING);
    end
  end

  // Clear sequencer next-state: walk ptr 0..DEPTH-1 once, then back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (i_clr) begin
          w_state_nxt = ST_CLEARING;
          w_ptr_nxt   = '0;
        end
      end
      ST_CLEARING: begin
        if (r_ptr == LAST) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Storage: cleared by reset or by the sequencer, otherwise written by the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == ST_CLEARING) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[w_w_idx] <= w_merged;
    end
  end

  // One-cycle pulse flagging a discarded write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_wr_drop;
    end
  end

  assign o_w_drop = r_drop;
  assign o_busy   = r_busy;

`ifdef REGISTER_BANK_PARITY_EN
  logic r_par [DEPTH];
  logic w_wr_par;

  // Even parity of the merged word; the injection input flips it for test.
  assign w_wr_par = (^w_merged) ^ i_perr_inj;

  // Parity storage tracks the data storage; a cleared word has parity 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_par[i] <= 1'b0;
      end
    end else if (r_state == ST_CLEARING) begin
      r_par[r_ptr] <= 1'b0;
    end else if (w_wr_ok) begin
      r_par[w_w_idx] <= w_wr_par;
    end
  end
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic             w_in_range;
    logic [AW-1:0]    w_idx;
    logic             w_fwd;
    logic             w_rd_ok;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] r_val;
    logic             r_valid;

    assign w_ra       = i_r_addr[p*AW +: AW];
    assign w_in_range = ({1'b0, w_ra} < DEPTH_W);
    assign w_idx      = w_in_range ? w_ra : '0;
    assign w_fwd      = w_wr_ok && (w_ra == i_w_addr);
    assign w_rd_ok    = i_r_en[p] && w_access_ok;
    assign w_data     = !w_in_range ? '0 : (w_fwd ? w_merged : r_mem[w_idx]);

    // Read pipeline: valid pulses per accepted request, data holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_val   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_ok;
        if (w_rd_ok) begin
          r_val <= w_data;
        end
      end
    end

    assign o_r_value[p*WIDTH +: WIDTH] = r_val;
    assign o_r_valid[p]                = r_valid;

`ifdef REGISTER_BANK_PARITY_EN
    logic w_par;
    logic r_perr;

    assign w_par = !w_in_range ? 1'b0 : (w_fwd ? w_wr_par : r_par[w_idx]);

    // Parity error flag, qualified with the same request as valid.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_perr <= 1'b0;
      end else begin
        r_perr <= w_rd_ok && ((^w_data) != w_par);
      end
    end

    assign o_r_perr[p] = r_perr;
`endif
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed self-checking bench for register_bank_mp (default parameters).
module tb_register_bank_mp;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                    clk;
  logic                    reset_n;
  logic                    i_w_en;
  logic [AW-1:0]           i_w_addr;
  logic [WIDTH-1:0]        i_w_value;
  logic [WIDTH/8-1:0]      i_w_strb;
  logic                    o_w_drop;
  logic [NUM_RD-1:0]       i_r_en;
  logic [NUM_RD*AW-1:0]    i_r_addr;
  logic [NUM_RD*WIDTH-1:0] o_r_value;
  logic [NUM_RD-1:0]       o_r_valid;
  logic                    i_clr;
  logic                    o_busy;
`ifdef REGISTER_BANK_PARITY_EN
  logic                    i_perr_inj;
  logic [NUM_RD-1:0]       o_r_perr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  register_bank_mp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NUM_RD(NUM_RD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_w_en   (i_w_en),
    .i_w_addr (i_w_addr),
    .i_w_value(i_w_value),
    .i_w_strb (i_w_strb),
    .o_w_drop (o_w_drop),
    .i_r_en   (i_r_en),
    .i_r_addr (i_r_addr),
    .o_r_value(o_r_value),
    .o_r_valid(o_r_valid),
    .i_clr    (i_clr),
    .o_busy   (o_busy)
`ifdef REGISTER_BANK_PARITY_EN
    ,
    .i_perr_inj(i_perr_inj),
    .o_r_perr  (o_r_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] v, input logic [3:0] s);
    i_w_en = 1'b1; i_w_addr = a; i_w_value = v; i_w_strb = s;
    tick();
    i_w_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    i_r_en = en; i_r_addr = {a1, a0};
    tick();
    i_r_en = '0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a += 2) begin
      rd(2'b11, AW'(a), AW'(a + 1));
      check_eq({tag, "_valid"}, 64'(o_r_valid), 64'h3);
      check_eq({tag, "_p0"}, 64'(o_r_value[31:0]), 64'h0);
      check_eq({tag, "_p1"}, 64'(o_r_value[63:32]), 64'h0);
    end
  endtask

  initial begin
    int n_busy;
    int guard;

    reset_n = 1'b1; i_w_en = 1'b0; i_w_addr = '0; i_w_value = '0; i_w_strb = '0;
    i_r_en = '0; i_r_addr = '0; i_clr = 1'b0;
`ifdef REGISTER_BANK_PARITY_EN
    i_perr_inj = 1'b0;
`endif
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_busy",  64'(o_busy), 64'h0);
    check_eq("rst_valid", 64'(o_r_valid), 64'h0);
    check_eq("rst_value", 64'(o_r_value), 64'h0);
    check_eq("rst_drop",  64'(o_w_drop), 64'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Reads after reset return zero on both ports.
    rd(2'b11, 5'd0, 5'd0);
    check_eq("r0_valid", 64'(o_r_valid), 64'h3);
    check_eq("r0_val",   64'(o_r_value), 64'h0);
    rd(2'b11, 5'd5, 5'd31);
    check_eq("r5_valid", 64'(o_r_valid), 64'h3);
    check_eq("r5_val",   64'(o_r_value), 64'h0);
    rd(2'b11, 5'd31, 5'd5);
    check_eq("r31_valid", 64'(o_r_valid), 64'h3);
    check_eq("r31_val",   64'(o_r_value), 64'h0);
    tick();
    check_eq("valid_pulse", 64'(o_r_valid), 64'h0);

    // Strobed partial write.
    wr(5'd3, 32'hDEADBEEF, 4'b1111);
    check_eq("wr_nodrop", 64'(o_w_drop), 64'h0);
    wr(5'd3, 32'h00001234, 4'b0011);
    rd(2'b10, 5'd0, 5'd3);
    check_eq("strb_valid", 64'(o_r_valid), 64'h2);
    check_eq("strb_p1",    64'(o_r_value[63:32]), 64'hDEAD1234);

    // All-zero strobe is a silent no-op.
    wr(5'd3, 32'hFFFFFFFF, 4'b0000);
    check_eq("zstrb_nodrop", 64'(o_w_drop), 64'h0);
    rd(2'b01, 5'd3, 5'd0);
    check_eq("zstrb_p0", 64'(o_r_value[31:0]), 64'hDEAD1234);
    check_eq("hold_p1",  64'(o_r_value[63:32]), 64'hDEAD1234);

    // Read-during-write forwarding.
    wr(5'd7, 32'h11223344, 4'b1111);
    i_w_en = 1'b1; i_w_addr = 5'd7; i_w_value = 32'hAABBCCDD; i_w_strb = 4'b1100;
    rd(2'b01, 5'd7, 5'd0);
    i_w_en = 1'b0;
    check_eq("fwd_valid", 64'(o_r_valid), 64'h1);
    check_eq("fwd_p0",    64'(o_r_value[31:0]), 64'hAABB3344);
    rd(2'b11, 5'd7, 5'd7);
    check_eq("same_addr", 64'(o_r_value), 64'hAABB3344AABB3344);

    // Fill, then clear; same-cycle write and read are dropped.
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'hFFFFFFFF, 4'b1111);
    i_clr = 1'b1;
    i_w_en = 1'b1; i_w_addr = 5'd0; i_w_value = 32'h77; i_w_strb = 4'hF;
    rd(2'b01, 5'd0, 5'd0);
    i_clr = 1'b0; i_w_en = 1'b0;
    check_eq("clr_busy",  64'(o_busy), 64'h1);
    check_eq("clr_wdrop", 64'(o_w_drop), 64'h1);
    check_eq("clr_rdrop", 64'(o_r_valid), 64'h0);
    n_busy = 1;
    tick();
    if (o_busy) n_busy++;
    wr(5'd0, 32'h12345678, 4'b1111);
    if (o_busy) n_busy++;
    check_eq("busy_wdrop", 64'(o_w_drop), 64'h1);
    i_clr = 1'b1;
    rd(2'b11, 5'd1, 5'd2);
    i_clr = 1'b0;
    if (o_busy) n_busy++;
    check_eq("busy_rdrop", 64'(o_r_valid), 64'h0);
    guard = 0;
    while (o_busy && guard < 100) begin
      tick();
      guard++;
      if (o_busy) n_busy++;
    end
    check_eq("busy_cycles", 64'(n_busy), 64'd32);
    check_eq("drop_cleared", 64'(o_w_drop), 64'h0);
    read_all_zero("post_clr");

    // Reset in the middle of a clear.
    wr(5'd20, 32'hCAFEF00D, 4'b1111);
    wr(5'd31, 32'h5A5A5A5A, 4'b1111);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    repeat (10) tick();
    check_eq("mid_busy", 64'(o_busy), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(o_busy), 64'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 64'(o_busy), 64'h0);
    read_all_zero("post_rst");
    wr(5'd4, 32'h0BADCAFE, 4'b1111);
    check_eq("idle_nodrop", 64'(o_w_drop), 64'h0);
    rd(2'b10, 5'd0, 5'd4);
    check_eq("idle_valid", 64'(o_r_valid), 64'h2);
    check_eq("idle_p1",    64'(o_r_value[63:32]), 64'h0BADCAFE);

`ifdef REGISTER_BANK_PARITY_EN
    i_perr_inj = 1'b1;
    wr(5'd2, 32'h00000001, 4'b1111);
    i_perr_inj = 1'b0;
    rd(2'b01, 5'd2, 5'd0);
    check_eq("perr_valid", 64'(o_r_valid), 64'h1);
    check_eq("perr_inj",   64'(o_r_perr), 64'h1);
    rd(2'b01, 5'd3, 5'd0);
    check_eq("perr_clean", 64'(o_r_perr), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
